// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - signal bundle between a requester and the alu_core datapath
//
// Purpose:
//   Groups the enables, opcodes, operands and interrupt-clear that drive the
//   ALU, together with its registered result and sticky interrupt flag.
//   Clock and reset are kept outside the bundle as plain ports.
//
// Signals:
//   alu_enable    requester -> alu   global enable, 0 = no operation
//   alu_enable_a  requester -> alu   select mode A (logic ops)
//   alu_enable_b  requester -> alu   select mode B (logic/arithmetic ops)
//   alu_op_a      requester -> alu   2-bit mode A opcode
//   alu_op_b      requester -> alu   2-bit mode B opcode
//   alu_in_a      requester -> alu   operand A
//   alu_in_b      requester -> alu   operand B
//   alu_irq_clr   requester -> alu   clear the sticky interrupt flag
//   alu_out       alu -> requester   registered result
//   alu_irq       alu -> requester   registered sticky interrupt flag

interface alu_core_if #(
  parameter int DATA_W = 8
);

  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq_clr;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;

  // Requester side: drives the request, observes result and flag.
  modport master (
    output alu_enable,
    output alu_enable_a,
    output alu_enable_b,
    output alu_op_a,
    output alu_op_b,
    output alu_in_a,
    output alu_in_b,
    output alu_irq_clr,
    input  alu_out,
    input  alu_irq
  );

  // ALU side: consumes the request, produces result and flag.
  modport slave (
    input  alu_enable,
    input  alu_enable_a,
    input  alu_enable_b,
    input  alu_op_a,
    input  alu_op_b,
    input  alu_in_a,
    input  alu_in_b,
    input  alu_irq_clr,
    output alu_out,
    output alu_irq
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered two-mode logic/arithmetic unit with sticky interrupt
//
// Purpose:
//   Executes one operation per clock when enabled with exactly one mode
//   selected. Mode A performs AND/NAND/OR/XOR; mode B performs
//   XNOR/NOR/ADD/SUB. Each opcode has an interrupt cause (a specific result
//   pattern, carry-out or borrow) that sets a sticky flag, cleared by
//   alu_irq_clr. Result and flag are the only state; both are registered.
//
// Ports:
//   alu_clk    input   system clock, rising-edge active
//   alu_rst_n  input   asynchronous reset, ACTIVE-HIGH despite the name
//   bus        slave   alu_core_if bundle (enables, opcodes, operands,
//                      irq clear in; alu_out, alu_irq out)

module alu_core #(
  parameter int DATA_W = 8
) (
  input  logic        alu_clk,
  input  logic        alu_rst_n,
  alu_core_if.slave   bus
);

  // Mode A opcodes
  localparam logic [1:0] OP_A_AND  = 2'b00;
  localparam logic [1:0] OP_A_NAND = 2'b01;
  localparam logic [1:0] OP_A_OR   = 2'b10;
  localparam logic [1:0] OP_A_XOR  = 2'b11;

  // Mode B opcodes
  localparam logic [1:0] OP_B_XNOR = 2'b00;
  localparam logic [1:0] OP_B_NOR  = 2'b01;
  localparam logic [1:0] OP_B_ADD  = 2'b10;
  localparam logic [1:0] OP_B_SUB  = 2'b11;

  // Result patterns that raise an interrupt cause for the logic ops.
  localparam logic [DATA_W-1:0] IRQ_AND  = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] IRQ_NAND = DATA_W'(8'h00);
  localparam logic [DATA_W-1:0] IRQ_OR   = DATA_W'(8'hF8);
  localparam logic [DATA_W-1:0] IRQ_XOR  = DATA_W'(8'h83);
  localparam logic [DATA_W-1:0] IRQ_XNOR = DATA_W'(8'hF1);
  localparam logic [DATA_W-1:0] IRQ_NOR  = DATA_W'(8'hF4);

  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              mode_a;
  logic              mode_b;
  logic              op_fire;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] diff;
  logic              borrow;

  logic [DATA_W-1:0] result;
  logic              cause;

  logic [DATA_W-1:0] out_q;
  logic              irq_q;

  assign in_a = bus.alu_in_a;
  assign in_b = bus.alu_in_b;

  // Exactly one mode must be selected; both-or-neither is treated as a hold.
  assign mode_a  = bus.alu_enable_a & ~bus.alu_enable_b;
  assign mode_b  = bus.alu_enable_b & ~bus.alu_enable_a;
  assign op_fire = bus.alu_enable & (mode_a | mode_b);

  // Arithmetic: carry is the extra top bit of the widened sum; borrow is
  // simply an unsigned compare, which avoids a second widened subtractor.
  assign sum_ext = {1'b0, in_a} + {1'b0, in_b};
  assign diff    = in_a - in_b;
  assign borrow  = (in_a < in_b);

  // Result and interrupt-cause decode. Only meaningful when op_fire is set;
  // otherwise the register below ignores both.
  always_comb begin
    result = '0;
    cause  = 1'b0;
    if (mode_a) begin
      case (bus.alu_op_a)
        OP_A_AND: begin
          result = in_a & in_b;
          cause  = (result == IRQ_AND);
        end
        OP_A_NAND: begin
          result = ~(in_a & in_b);
          cause  = (result == IRQ_NAND);
        end
        OP_A_OR: begin
          result = in_a | in_b;
          cause  = (result == IRQ_OR);
        end
        default: begin
          result = in_a ^ in_b;
          cause  = (result == IRQ_XOR);
        end
      endcase
    end else if (mode_b) begin
      case (bus.alu_op_b)
        OP_B_XNOR: begin
          result = ~(in_a ^ in_b);
          cause  = (result == IRQ_XNOR);
        end
        OP_B_NOR: begin
          result = ~(in_a | in_b);
          cause  = (result == IRQ_NOR);
        end
        OP_B_ADD: begin
          result = sum_ext[DATA_W-1:0];
          cause  = sum_ext[DATA_W];
        end
        default: begin
          result = diff;
          cause  = borrow;
        end
      endcase
    end
  end

  // Result register: loads only on a fired op, otherwise holds.
  always_ff @(posedge alu_clk or posedge alu_rst_n) begin
    if (alu_rst_n) begin
      out_q <= '0;
    end else if (op_fire) begin
      out_q <= result;
    end
  end

  // Sticky interrupt. A new cause has priority over a clear at the same
  // edge so an event is never lost; the clear works even while disabled.
  always_ff @(posedge alu_clk or posedge alu_rst_n) begin
    if (alu_rst_n) begin
      irq_q <= 1'b0;
    end else if (op_fire && cause) begin
      irq_q <= 1'b1;
    end else if (bus.alu_irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.alu_out = out_q;
  assign bus.alu_irq = irq_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core

module tb_alu_core;

  logic alu_clk = 1'b0;
  logic alu_rst_n;

  alu_core_if #(.DATA_W(8)) bus ();

  alu_core #(.DATA_W(8)) dut (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .bus       (bus)
  );

  always #10 alu_clk = ~alu_clk;

  typedef struct {
    logic [7:0] o;
    logic       i;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Drives one cycle of stimulus (at a falling edge) and records the result
  // the bench expects to see after the next rising edge.
  task automatic drive(input logic en, input logic ea, input logic eb,
                       input logic [1:0] oa, input logic [1:0] ob,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic clr, input logic [7:0] eo, input logic ei,
                       input string nm);
    bus.alu_enable   = en;
    bus.alu_enable_a = ea;
    bus.alu_enable_b = eb;
    bus.alu_op_a     = oa;
    bus.alu_op_b     = ob;
    bus.alu_in_a     = a;
    bus.alu_in_b     = b;
    bus.alu_irq_clr  = clr;
    sb.push_back('{o: eo, i: ei, name: nm});
  endtask

  task automatic idle_inputs();
    bus.alu_enable   = 1'b0;
    bus.alu_enable_a = 1'b0;
    bus.alu_enable_b = 1'b0;
    bus.alu_op_a     = 2'b00;
    bus.alu_op_b     = 2'b00;
    bus.alu_in_a     = 8'h00;
    bus.alu_in_b     = 8'h00;
    bus.alu_irq_clr  = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    alu_rst_n = 1'b1;
    #25;
    n_cmp++;
    if (bus.alu_out !== 8'h00 || bus.alu_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_initial: out=%h irq=%b required out=00 irq=0", bus.alu_out, bus.alu_irq);
    end
    @(negedge alu_clk);
    alu_rst_n = 1'b0;
    // Load nonzero state so the asynchronous clear is observable.
    drive(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0, 8'hFF, 1'b1, "reset_preload");
    @(posedge alu_clk); @(negedge alu_clk);
    e = sb.pop_front();
    n_cmp++;
    if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
      n_bad++;
      $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
    end
    // Valid op pending while reset hits mid-cycle: it must be discarded.
    bus.alu_enable   = 1'b1;
    bus.alu_enable_a = 1'b0;
    bus.alu_enable_b = 1'b1;
    bus.alu_op_b     = 2'b10;
    bus.alu_in_a     = 8'hFF;
    bus.alu_in_b     = 8'h01;
    #4;
    alu_rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.alu_out !== 8'h00 || bus.alu_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: out=%h irq=%b required out=00 irq=0", bus.alu_out, bus.alu_irq);
    end
    @(posedge alu_clk); @(posedge alu_clk); @(negedge alu_clk);
    n_cmp++;
    if (bus.alu_out !== 8'h00 || bus.alu_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held: out=%h irq=%b required out=00 irq=0", bus.alu_out, bus.alu_irq);
    end
    idle_inputs();
    alu_rst_n = 1'b0;
  endtask

  task automatic test_mode_a_sweep();
    logic [7:0] exp_tab [4];
    exp_t e;
    exp_tab = '{8'h30, 8'hCF, 8'hFC, 8'hCC};
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 2'(k), 2'b00, 8'hF0, 8'h3C, 0, exp_tab[k], 1'b0, $sformatf("sweep_a_op%0d", k));
      @(posedge alu_clk); @(negedge alu_clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep_a: scoreboard empty, required an entry");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.alu_out !== e.o) begin
          n_bad++;
          $display("FAIL %s out: got %h required %h", e.name, bus.alu_out, e.o);
        end
        n_cmp++;
        if (bus.alu_irq !== e.i) begin
          n_bad++;
          $display("FAIL %s irq: got %b required %b", e.name, bus.alu_irq, e.i);
        end
      end
    end
  endtask

  task automatic test_mode_a_irq();
    exp_t e;
    drive(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0, 8'hFF, 1'b1, "a_irq_and");
    for (int k = 0; k < 3; k++) begin
      @(posedge alu_clk); @(negedge alu_clk);
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
      if (k == 0) drive(1, 1, 0, 2'b11, 2'b00, 8'h01, 8'h02, 0, 8'h03, 1'b1, "a_irq_sticky");
      if (k == 1) drive(0, 0, 0, 2'b00, 2'b00, 8'h55, 8'hAA, 1, 8'h03, 1'b0, "a_irq_clear");
    end
  endtask

  task automatic test_mode_b_arith();
    exp_t e;
    drive(1, 0, 1, 2'b00, 2'b10, 8'hF0, 8'h20, 0, 8'h10, 1'b1, "b_add_carry");
    for (int k = 0; k < 5; k++) begin
      @(posedge alu_clk); @(negedge alu_clk);
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
      case (k)
        0: drive(0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 8'h10, 1'b0, "b_clear1");
        1: drive(1, 0, 1, 2'b00, 2'b11, 8'h05, 8'h07, 0, 8'hFE, 1'b1, "b_sub_borrow");
        2: drive(0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 8'hFE, 1'b0, "b_clear2");
        3: drive(1, 0, 1, 2'b00, 2'b11, 8'h07, 8'h05, 0, 8'h02, 1'b0, "b_sub_noborrow");
        default: ;
      endcase
    end
  endtask

  // Each remaining irq pattern, each followed by a clear that also runs an op.
  task automatic test_irq_patterns();
    exp_t e;
    logic       ea_t [5];
    logic [1:0] op_t [5];
    logic [7:0] a_t  [5];
    logic [7:0] b_t  [5];
    logic [7:0] r_t  [5];
    ea_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    op_t = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    a_t  = '{8'hFF, 8'hF0, 8'h80, 8'h0E, 8'h80};
    b_t  = '{8'hFF, 8'h08, 8'h03, 8'h00, 8'h7F};
    r_t  = '{8'h00, 8'hF8, 8'h83, 8'hF1, 8'hFF};
    for (int k = 0; k < 5; k++) begin
      // Last entry is ADD 0x80+0x7F = 0xFF, the no-carry boundary.
      drive(1, ea_t[k], ~ea_t[k], op_t[k], op_t[k], a_t[k], b_t[k], 0, r_t[k], (k != 4),
            $sformatf("pattern%0d", k));
      @(posedge alu_clk); @(negedge alu_clk);
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
      // Clear while an enabled, non-causing XOR executes.
      drive(1, 1, 0, 2'b11, 2'b00, 8'h00, 8'h01, 1, 8'h01, 1'b0, $sformatf("pattern%0d_clr", k));
      @(posedge alu_clk); @(negedge alu_clk);
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
    end
  endtask

  task automatic test_clear_set_collision();
    exp_t e;
    drive(1, 0, 1, 2'b00, 2'b10, 8'hFF, 8'h01, 0, 8'h00, 1'b1, "coll_setup");
    @(posedge alu_clk); @(negedge alu_clk);
    drive(1, 0, 1, 2'b00, 2'b01, 8'h0B, 8'h00, 1, 8'hF4, 1'b1, "coll_nor_clr");
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        @(posedge alu_clk); @(negedge alu_clk);
      end
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
    end
  endtask

  // Entry: out=F4, irq=1 from the collision test.
  task automatic test_hold();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(0, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0, 8'hF4, 1'b1, "hold_dis_and");
        1: drive(0, 0, 1, 2'b00, 2'b11, 8'($urandom), 8'($urandom), 0, 8'hF4, 1'b1, "hold_dis_rand");
        2: drive(1, 1, 1, 2'b00, 2'b10, 8'h12, 8'h34, 0, 8'hF4, 1'b1, "hold_both");
        3: drive(0, 0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 8'hF4, 1'b0, "hold_clear");
        4: drive(1, 1, 1, 2'b00, 2'b10, 8'hFF, 8'hFF, 0, 8'hF4, 1'b0, "hold_both_cause");
        default: drive(1, 0, 0, 2'b00, 2'b00, 8'hFF, 8'hFF, 0, 8'hF4, 1'b0, "hold_neither");
      endcase
      @(posedge alu_clk); @(negedge alu_clk);
      e = sb.pop_front();
      n_cmp++;
      if (bus.alu_out !== e.o || bus.alu_irq !== e.i) begin
        n_bad++;
        $display("FAIL %s: out=%h irq=%b required out=%h irq=%b", e.name, bus.alu_out, bus.alu_irq, e.o, e.i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_a_sweep();
    test_mode_a_irq();
    test_mode_b_arith();
    test_irq_patterns();
    test_clear_set_collision();
    test_hold();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
